csa_accumulator: RTL and testbench
==================================

# csa_accumulator

Parametrised carry-save accumulator for the ECC datapath: sums an arbitrary-length stream of WIDTH-bit operands in redundant (sum, carry) form at one operand per cycle with no carry propagation, then resolves to binary with a multi-cycle, chunked carry-propagate pass on request. It is the sequential, multi-operand successor to the single-bit half/full adder cells in the csa library. It feeds the modular-reduction stage through a valid/ready output.

## Interface
- WIDTH, 256: operand width in bits.
- GUARD, 8: guard bits above WIDTH. ACC_W = WIDTH+GUARD.
- CHUNK, 32: bits resolved per cycle in the final add. NCHUNK = ceil(ACC_W/CHUNK); the top chunk may be partial.

- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- clr  in  1  abort and zero the accumulator; any state.
- in_vld  in  1  operand valid.
- in_dat  in  WIDTH  operand, zero-extended to ACC_W.
- in_rdy  out  1  operand/fin accept; =1 only in ACC and rst_n high.
- fin  in  1  end of stream; accepted when fin&in_rdy.
- out_vld  out  1  resolved result valid.
- out_dat  out  ACC_W  resolved sum mod 2^ACC_W.
- out_rdy  in  1  downstream accept.
- busy  out  1  high in RESOLVE or DONE.

## Operation
- Registers: S[ACC_W], C[ACC_W], chunk index k, carry bit cb, state.
- States: ACC, RESOLVE, DONE.
- ACC: on in_vld&in_rdy, apply a 3:2 compress: S' = S^C^X; C' = ((S&C)|(S&X)|(C&X))<<1, truncated to ACC_W, where X = zext(in_dat). Bits shifted out of the MSB are dropped, giving mod 2^ACC_W wrap.
- Fin: on fin&in_rdy, enter RESOLVE with k=0, cb=0.
  - If in_vld is also high in the same cycle, the operand is compressed first; it is included in the result.
  - If fin is accepted with no prior operands, the result is 0.
- RESOLVE, one chunk per cycle:
  - {cb, S[k]} <= S[k] + C[k] + cb.
  - k++.
  - After chunk NCHUNK-1, go to DONE; the final carry-out is dropped.
- DONE: out_dat = S, out_vld = 1, held stable until out_rdy. On out_vld&out_rdy, go to ACC with S = C = 0.
- clr, when rst_n is high, has priority over everything:
  - next state ACC; S, C, k, cb all cleared; out_vld drops next cycle.
  - Any concurrent operand or fin is discarded.
- Reset (rst_n low at an edge): state ACC; S, C, k, cb = 0. Outputs out_vld = 0, out_dat = 0, busy = 0. in_rdy = 0 while rst_n is low.
- Reset mid-RESOLVE or mid-DONE discards all work.

## Timing
- Accumulate throughput: 1 operand per cycle, zero bubbles. in_rdy is combinational from state and rst_n.
- in_rdy falls in the cycle after fin is accepted.
- Latency:
  - fin accepted at edge T, then chunks are processed at edges T+1 .. T+NCHUNK.
  - out_vld is high from T+NCHUNK onward (defaults: 9 cycles).
- First operand can be accepted:
  - in the cycle after the out_vld&out_rdy handshake edge;
  - one cycle after clr.
- out_dat changes only on the entry to DONE, on clr, or on reset. It is stable while out_vld&!out_rdy.
- busy = (state != ACC), registered with state.
- No combinational path from in_* to out_*.

## Structure
- Package csa_pkg holds:
  - state enum csa_state_e {ACC, RESOLVE, DONE};
  - function nchunk(ACC_W, CHUNK);
  - localparam helpers for chunk slicing of the partial top chunk.
- Sub-module csa_3to2 #(W): purely combinational vector 3:2 compressor (a, b, c → sum, carry<<1 truncated). It is built from the existing full-adder cell logic and reused by later multi-operand trees.
- The top level holds the FSM, registers and chunk adder (CHUNK-bit + cb).

## Test plan
Configuration: WIDTH=8, GUARD=4, CHUNK=4 (ACC_W=12, NCHUNK=3) unless noted.
- 16 × in_dat=0xFF back-to-back, then fin → out_dat=0xFF0, out_vld exactly 3 edges after fin accept, in_rdy high on all 16 cycles.
- 17 × 0xFF, with fin in the same cycle as the 17th operand → out_dat=0x0EF (4335 mod 4096): wrap plus simultaneous operand/fin.
- fin immediately after reset with no operands → out_dat=0x000, out_vld after 3 cycles.
- Result 0x123: hold out_rdy low for 5 cycles → out_vld/out_dat stable, in_rdy=0, busy=1; after the handshake the next stream 3+4 gives 0x007.
- clr asserted during RESOLVE (k=1) → no out_vld ever; then operands 3, 4 and fin → out_dat=0x007. Repeat with rst_n low mid-DONE → out_vld=0 next cycle, out_dat=0.
- Defaults (256/8/32): 300 random operands → out_dat equals the reference sum mod 2^264, latency 9.

Source files
------------

// File: rtl/csa_pkg.sv
// Shared types and sizing helpers for the carry-save accumulator family.
// The final carry-propagate pass works on CHUNK-bit slices; the top slice may be partial.
package csa_pkg;

  typedef enum logic [1:0] {
    ACC     = 2'd0,
    RESOLVE = 2'd1,
    DONE    = 2'd2
  } csa_state_e;

  function automatic int nchunk(input int acc_w, input int chunk);
    return (acc_w + chunk - 1) / chunk;
  endfunction

  // Width of the most significant slice; equals chunk when acc_w divides evenly.
  function automatic int top_chunk_w(input int acc_w, input int chunk);
    return acc_w - (nchunk(acc_w, chunk) - 1) * chunk;
  endfunction

endpackage

// File: rtl/csa_3to2.sv
// Vector 3:2 compressor: one full-adder cell per bit, carries shifted up one place.
// The carry out of the MSB is dropped, giving mod 2^W behaviour.
module csa_3to2 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  logic [W-1:0] maj;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i] = a[i] ^ b[i] ^ c[i];
    assign maj[i] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign carry = maj << 1;

endmodule

// File: rtl/csa_accumulator.sv
// Multi-operand accumulator held in redundant (sum, carry) form, one operand per cycle,
// resolved to binary by a chunked carry-propagate pass and handed off over valid/ready.
module csa_accumulator
  import csa_pkg::*;
#(
  parameter int WIDTH = 256,
  parameter int GUARD = 8,
  parameter int CHUNK = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     in_vld,
  input  logic [WIDTH-1:0]         in_dat,
  output logic                     in_rdy,
  input  logic                     fin,
  output logic                     out_vld,
  output logic [WIDTH+GUARD-1:0]   out_dat,
  input  logic                     out_rdy,
  output logic                     busy
);

  localparam int ACC_W  = WIDTH + GUARD;
  localparam int NCHUNK = nchunk(ACC_W, CHUNK);
  localparam int TOP_W  = top_chunk_w(ACC_W, CHUNK);
  localparam int PAD_W  = ACC_W + CHUNK - TOP_W;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  csa_state_e        state, state_next;
  logic [ACC_W-1:0]  s, c, out_reg, x, cmp_sum, cmp_carry, res_s;
  logic [KW-1:0]     k;
  logic              cb, res_cb, last_chunk;
  logic [PAD_W-1:0]  s_pad, c_pad, s_pad_next;
  logic [CHUNK:0]    chunk_sum;

  assign x = ACC_W'(in_dat);

  csa_3to2 #(.W(ACC_W)) u_csa (
    .a     (s),
    .b     (c),
    .c     (x),
    .sum   (cmp_sum),
    .carry (cmp_carry)
  );

  // Zero padding lets a partial top slice use the same CHUNK-bit adder; its carry-out lands
  // in the padding and is discarded when truncating back to ACC_W.
  always_comb begin
    s_pad      = PAD_W'(s);
    c_pad      = PAD_W'(c);
    s_pad_next = s_pad;
    chunk_sum  = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (k == KW'(i)) begin
        chunk_sum = {1'b0, s_pad[i*CHUNK +: CHUNK]} + {1'b0, c_pad[i*CHUNK +: CHUNK]}
                  + {{CHUNK{1'b0}}, cb};
        s_pad_next[i*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
      end
    end
    res_s  = s_pad_next[ACC_W-1:0];
    res_cb = chunk_sum[CHUNK];
  end

  assign last_chunk = (k == KW'(NCHUNK - 1));

  always_comb begin
    state_next = state;
    case (state)
      ACC:     if (fin)        state_next = RESOLVE;
      RESOLVE: if (last_chunk) state_next = DONE;
      DONE:    if (out_rdy)    state_next = ACC;
      default:                 state_next = ACC;
    endcase
    if (clr) state_next = ACC;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ACC;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      s       <= '0;
      c       <= '0;
      k       <= '0;
      cb      <= 1'b0;
      out_reg <= '0;
    end else begin
      case (state)
        ACC: begin
          if (in_vld) begin
            s <= cmp_sum;
            c <= cmp_carry;
          end
          if (fin) begin
            k  <= '0;
            cb <= 1'b0;
          end
        end
        RESOLVE: begin
          s  <= res_s;
          cb <= res_cb;
          k  <= k + 1'b1;
          if (last_chunk) out_reg <= res_s;
        end
        DONE: begin
          if (out_rdy) begin
            s <= '0;
            c <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_rdy  = rst_n && (state == ACC);
  assign out_vld = (state == DONE);
  assign out_dat = out_reg;
  assign busy    = (state != ACC);

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed bench for csa_accumulator: a small 8/4/4 instance and a default 256/8/32 instance,
// both shadowed by an arithmetic reference model compared on every falling edge.
module tb_csa_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         s_rst_n, s_clr, s_in_vld, s_in_rdy, s_fin, s_out_vld, s_out_rdy, s_busy;
  logic [7:0]   s_in_dat;
  logic [11:0]  s_out_dat;
  logic         b_rst_n, b_clr, b_in_vld, b_in_rdy, b_fin, b_out_vld, b_out_rdy, b_busy;
  logic [255:0] b_in_dat;
  logic [263:0] b_out_dat;

  csa_accumulator #(.WIDTH(8), .GUARD(4), .CHUNK(4)) u_small (
    .clk(clk), .rst_n(s_rst_n), .clr(s_clr), .in_vld(s_in_vld), .in_dat(s_in_dat),
    .in_rdy(s_in_rdy), .fin(s_fin), .out_vld(s_out_vld), .out_dat(s_out_dat),
    .out_rdy(s_out_rdy), .busy(s_busy)
  );

  csa_accumulator #(.WIDTH(256), .GUARD(8), .CHUNK(32)) u_big (
    .clk(clk), .rst_n(b_rst_n), .clr(b_clr), .in_vld(b_in_vld), .in_dat(b_in_dat),
    .in_rdy(b_in_rdy), .fin(b_fin), .out_vld(b_out_vld), .out_dat(b_out_dat),
    .out_rdy(b_out_rdy), .busy(b_busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [263:0] act, input logic [263:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a running modular sum, a phase (0 accept, 1 resolving, 2 result held) and
  // a countdown to the result; index 0 is the small instance, 1 the default instance.
  logic [263:0] m_sum [2];
  logic [263:0] m_out [2];
  logic [263:0] m_mask[2];
  int           m_phase[2];
  int           m_cnt  [2];
  int           m_nch  [2];

  initial begin
    m_mask[0] = 264'hFFF;  m_nch[0] = 3;
    m_mask[1] = '1;        m_nch[1] = 9;
    for (int i = 0; i < 2; i++) begin
      m_sum[i] = '0; m_out[i] = '0; m_phase[i] = 0; m_cnt[i] = 0;
    end
  end

  task automatic model_step(input int i, input logic rn, input logic cl, input logic vld,
                            input logic [263:0] din, input logic fn, input logic rdy);
    if (!rn || cl) begin
      m_phase[i] = 0; m_sum[i] = '0; m_out[i] = '0;
    end else begin
      case (m_phase[i])
        0: begin
          if (vld) m_sum[i] = (m_sum[i] + din) & m_mask[i];
          if (fn) begin m_phase[i] = 1; m_cnt[i] = 0; end
        end
        1: begin
          m_cnt[i]++;
          if (m_cnt[i] == m_nch[i]) begin m_phase[i] = 2; m_out[i] = m_sum[i]; end
        end
        default: if (rdy) begin m_phase[i] = 0; m_sum[i] = '0; end
      endcase
    end
  endtask

  always @(posedge clk) begin
    model_step(0, s_rst_n, s_clr, s_in_vld, 264'(s_in_dat), s_fin, s_out_rdy);
    model_step(1, b_rst_n, b_clr, b_in_vld, 264'(b_in_dat), b_fin, b_out_rdy);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("s_out_vld", 264'(s_out_vld), 264'(m_phase[0] == 2));
      chk("s_out_dat", 264'(s_out_dat), m_out[0]);
      chk("s_busy",    264'(s_busy),    264'(m_phase[0] != 0));
      chk("s_in_rdy",  264'(s_in_rdy),  264'(m_phase[0] == 0 && s_rst_n));
      chk("b_out_vld", 264'(b_out_vld), 264'(m_phase[1] == 2));
      chk("b_out_dat", b_out_dat,       m_out[1]);
      chk("b_busy",    264'(b_busy),    264'(m_phase[1] != 0));
      chk("b_in_rdy",  264'(b_in_rdy),  264'(m_phase[1] == 0 && b_rst_n));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic s_push(input logic [7:0] d, input logic f);
    s_in_vld = 1'b1; s_in_dat = d; s_fin = f;
    chk("s_in_rdy_stream", 264'(s_in_rdy), 264'(1));
    tick();
    s_in_vld = 1'b0; s_fin = 1'b0;
  endtask

  task automatic s_fin_only();
    s_fin = 1'b1;
    tick();
    s_fin = 1'b0;
  endtask

  task automatic s_wait(output int lat);
    lat = 0;
    while (!s_out_vld && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic s_ack();
    s_out_rdy = 1'b1;
    tick();
    s_out_rdy = 1'b0;
  endtask

  int lat;
  logic [255:0] d;
  logic [263:0] ref_sum;

  initial begin
    s_rst_n = 1'b0; s_clr = 1'b0; s_in_vld = 1'b0; s_in_dat = '0; s_fin = 1'b0; s_out_rdy = 1'b0;
    b_rst_n = 1'b0; b_clr = 1'b0; b_in_vld = 1'b0; b_in_dat = '0; b_fin = 1'b0; b_out_rdy = 1'b0;
    tick();
    chk_en = 1'b1;
    chk("rst_out_vld", 264'(s_out_vld), 264'(0));
    chk("rst_out_dat", 264'(s_out_dat), 264'(0));
    chk("rst_in_rdy",  264'(s_in_rdy),  264'(0));
    chk("rst_busy",    264'(s_busy),    264'(0));
    tick();
    s_rst_n = 1'b1; b_rst_n = 1'b1;
    tick();

    // 16 x 0xFF then a lone fin
    for (int i = 0; i < 16; i++) s_push(8'hFF, 1'b0);
    s_fin_only();
    s_wait(lat);
    chk("t1_latency", 264'(lat), 264'(3));
    chk("t1_dat", 264'(s_out_dat), 264'h0FF0);
    s_ack();
    chk("t1_rdy_after_ack", 264'(s_in_rdy), 264'(1));

    // 17 x 0xFF with fin on the 17th: wraps mod 4096
    for (int i = 0; i < 16; i++) s_push(8'hFF, 1'b0);
    s_push(8'hFF, 1'b1);
    s_wait(lat);
    chk("t2_latency", 264'(lat), 264'(3));
    chk("t2_dat", 264'(s_out_dat), 264'h0EF);
    s_ack();

    // fin with no operands right after reset
    s_rst_n = 1'b0; tick(); s_rst_n = 1'b1;
    s_fin_only();
    s_wait(lat);
    chk("t3_latency", 264'(lat), 264'(3));
    chk("t3_dat", 264'(s_out_dat), 264'h000);
    s_ack();

    // 0xFF + 0x24 = 0x123 held under back-pressure, then 3 + 4
    s_push(8'hFF, 1'b0);
    s_push(8'h24, 1'b0);
    s_fin_only();
    s_wait(lat);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_vld",  264'(s_out_vld), 264'(1));
      chk("t4_hold_dat",  264'(s_out_dat), 264'h123);
      chk("t4_hold_rdy",  264'(s_in_rdy),  264'(0));
      chk("t4_hold_busy", 264'(s_busy),    264'(1));
      tick();
    end
    s_ack();
    s_push(8'h03, 1'b0);
    s_push(8'h04, 1'b1);
    s_wait(lat);
    chk("t4_next_dat", 264'(s_out_dat), 264'h007);
    s_ack();

    // clr while resolving chunk 1, then a fresh stream
    s_push(8'h55, 1'b0);
    s_push(8'h66, 1'b0);
    s_fin_only();
    tick();
    s_clr = 1'b1; tick(); s_clr = 1'b0;
    repeat (6) tick();
    chk("t5_no_vld", 264'(s_out_vld), 264'(0));
    chk("t5_clr_dat", 264'(s_out_dat), 264'(0));
    s_push(8'h03, 1'b0);
    s_push(8'h04, 1'b0);
    s_fin_only();
    s_wait(lat);
    chk("t5_latency", 264'(lat), 264'(3));
    chk("t5_dat", 264'(s_out_dat), 264'h007);

    // reset while the result is held
    s_rst_n = 1'b0; tick();
    chk("t6_vld", 264'(s_out_vld), 264'(0));
    chk("t6_dat", 264'(s_out_dat), 264'(0));
    chk("t6_busy", 264'(s_busy), 264'(0));
    s_rst_n = 1'b1; tick();

    // default configuration: 300 random operands
    ref_sum = '0;
    for (int i = 0; i < 300; i++) begin
      for (int j = 0; j < 8; j++) d[j*32 +: 32] = $urandom();
      ref_sum = ref_sum + 264'(d);
      b_in_vld = 1'b1; b_in_dat = d;
      tick();
    end
    b_in_vld = 1'b0;
    b_fin = 1'b1; tick(); b_fin = 1'b0;
    lat = 0;
    while (!b_out_vld && lat < 40) begin
      tick();
      lat++;
    end
    chk("big_latency", 264'(lat), 264'(9));
    chk("big_dat", b_out_dat, ref_sum);
    b_out_rdy = 1'b1; tick(); b_out_rdy = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
